reflet_int_to_float_seq: RTL and testbench



---
 rtl/reflet_int_to_float_seq_if.sv | 20 ++
 rtl/reflet_int_to_float_seq.sv | 106 ++++++++++
 tb/tb_reflet_int_to_float_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reflet_int_to_float_seq_if.sv
// Handshake bundle between an integer producer and the int-to-float converter.
// The master drives the operand and consumes the result. The slave is the converter.
interface reflet_int_to_float_seq_if #(parameter int int_size = 32);
    logic [int_size-1:0] int_in;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         float_out;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output int_in, in_valid, out_ready,
        input  in_ready, float_out, out_valid
    );

    modport slave (
        input  int_in, in_valid, out_ready,
        output in_ready, float_out, out_valid
    );
endinterface

// File: rtl/reflet_int_to_float_seq.sv
// Sequential signed-integer to IEEE-754 single converter.
// It normalises one bit per clock and rounds to nearest-even.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting mag left until its MSB is set
// ROUND | round-to-nearest-even and pack the result
// DONE  | result held on float_out, out_valid high
module reflet_int_to_float_seq #(
    parameter int int_size = 32
) (
    input  logic clk,
    input  logic reset,
    reflet_int_to_float_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam int          ext_w    = int_size + 24;
    localparam logic [7:0]  exp_init = 8'(127 + int_size - 1);

    state_t              state, state_nx;
    logic                sign, sign_nx;
    logic [int_size-1:0] mag, mag_nx;
    logic [7:0]          exp, exp_nx;
    logic [31:0]         float_q, float_nx;

    logic [int_size-1:0] abs_in;
    logic [ext_w-1:0]    ext;
    logic [22:0]         m;
    logic                g, s, rnd_up;
    logic [23:0]         m_inc;

    // Negating the most negative value wraps to 100..0, which is its true magnitude.
    assign abs_in = bus.int_in[int_size-1] ? ((~bus.int_in) + int_size'(1)) : bus.int_in;

    // Zero padding below mag makes narrow inputs share the wide rounding path.
    assign ext    = {mag, 24'd0};
    assign m      = ext[ext_w-2 -: 23];
    assign g      = ext[ext_w-25];
    assign s      = |ext[ext_w-26:0];
    assign rnd_up = g & (s | m[0]);
    assign m_inc  = {1'b0, m} + 24'(rnd_up);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            exp     <= 8'd0;
            float_q <= 32'd0;
        end else begin
            state   <= state_nx;
            sign    <= sign_nx;
            mag     <= mag_nx;
            exp     <= exp_nx;
            float_q <= float_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sign_nx  = sign;
        mag_nx   = mag;
        exp_nx   = exp;
        float_nx = float_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_nx = bus.int_in[int_size-1];
                    mag_nx  = abs_in;
                    exp_nx  = exp_init;
                    if (bus.int_in == '0) begin
                        float_nx = 32'd0;
                        state_nx = DONE;
                    end else begin
                        state_nx = NORM;
                    end
                end
            end
            NORM: begin
                if (mag[int_size-1]) begin
                    state_nx = ROUND;
                end else begin
                    mag_nx = mag << 1;
                    exp_nx = exp - 8'd1;
                end
            end
            ROUND: begin
                if (m_inc[23])
                    float_nx = {sign, exp + 8'd1, 23'd0};
                else
                    float_nx = {sign, exp, m_inc[22:0]};
                state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.float_out = float_q;
endmodule

// File: tb/tb_reflet_int_to_float_seq.sv
// Bench for reflet_int_to_float_seq: directed cases plus random operands
// checked against an arithmetic reference conversion.
module tb_reflet_int_to_float_seq;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    reflet_int_to_float_seq_if #(.int_size(32)) bus ();

    reflet_int_to_float_seq #(.int_size(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: locate the top set bit, then round the discarded remainder
    // against exactly one half ulp, ties going to the even quotient.
    function automatic logic [31:0] ref_float(input logic signed [31:0] v);
        longint a, q, rem, half;
        int     p, sh, e;
        logic   sg;
        if (v == 0) return 32'd0;
        sg = v[31];
        a  = sg ? -longint'(v) : longint'(v);
        p  = 0;
        for (int i = 0; i < 63; i++) if ((a >> i) != 0) p = i;
        e = 127 + p;
        if (p <= 23) begin
            q = a << (23 - p);
        end else begin
            sh   = p - 23;
            q    = a >> sh;
            rem  = a & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {sg, 8'(e), q[22:0]};
    endfunction

    // Clock edges after the accept edge until out_valid is seen. Zero goes
    // straight to DONE on the accept edge, so it is already valid in the next cycle.
    function automatic int ref_lat(input logic signed [31:0] v);
        longint a;
        int     p;
        if (v == 0) return 0;
        a = v[31] ? -longint'(v) : longint'(v);
        p = 0;
        for (int i = 0; i < 63; i++) if ((a >> i) != 0) p = i;
        return (31 - p) + 2;
    endfunction

    // Called at a negedge with the DUT idle.
    task automatic convert(input logic [31:0] v, output logic [31:0] f, output int n);
        chk("idle_in_ready", bus.in_ready, 1);
        bus.int_in   = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            chk("busy_in_ready", bus.in_ready, 0);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", bus.out_valid, 1);
        f = bus.float_out;
        chk("model_float", f, ref_float(v));
        chk("model_latency", 64'(n), 64'(ref_lat(v)));
        if (bus.out_ready) begin
            @(posedge clk);
            @(negedge clk);
            chk("back_idle_ready", bus.in_ready, 1);
            chk("back_idle_valid", bus.out_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] f, r;
        int          n;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.int_in    = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_float", bus.float_out, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        convert(32'd5, f, n);
        chk("pos5", f, 32'h40A00000);
        chk("pos5_lat", 64'(n), 31);
        convert(32'd0, f, n);
        chk("zero", f, 32'h00000000);
        convert(-32'sd15, f, n);
        chk("neg15", f, 32'hC1700000);
        convert(32'h80000000, f, n);
        chk("minint", f, 32'hCF000000);
        chk("minint_lat", 64'(n), 2);
        convert(32'd16777217, f, n);
        chk("tie_even", f, 32'h4B800000);
        convert(32'd16777219, f, n);
        chk("tie_up", f, 32'h4B800002);
        convert(32'h7FFFFFFF, f, n);
        chk("mant_ovf", f, 32'h4F000000);
        convert(32'd1, f, n);
        chk("one_lat", 64'(n), 33);

        // Backpressure: hold DONE for four cycles while poking the input side.
        bus.out_ready = 1'b0;
        convert(32'd28, f, n);
        chk("bp_float", f, 32'h41E00000);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.int_in   = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_float", bus.float_out, 32'h41E00000);
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_float", bus.float_out, 32'h41E00000);

        // Reset while normalising 1 (31 shifts pending).
        bus.int_in   = 32'd1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_float", bus.float_out, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", bus.out_valid, 0);
        end
        convert(32'd12, f, n);
        chk("post_rst_12", f, 32'h41400000);

        for (int i = 0; i < 60; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
            convert(r, f, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
